// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common -- shared types, constants and helpers for the memory-access stage.
//
// Contents:
//   instr_field        decoded RV32 instruction fields (32-bit packed struct)
//   mem_state_t        memory-access FSM states
//   OPCODE_*           load/store major opcodes
//   F3_*               load/store funct3 encodings
//   load_wb_mask()     write-back mask for a load funct3
//   is_misaligned()    alignment check for an access size and address
//   store_strobe()     byte strobes for a store
//   store_data()       lane-replicated store data
// -----------------------------------------------------------------------------
package common;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_field;

    // Unsigned loads are zero-extended downstream by this mask; the data
    // path itself always sign-extends sub-word loads.
    function automatic logic [31:0] load_wb_mask(input logic [2:0] funct3);
        logic [31:0] mask;
        case (funct3)
            F3_LBU:  mask = 32'h0000_00FF;
            F3_LHU:  mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            default: bad = |addr_lo;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3)
            F3_SB:   strb = 4'b0001 << addr_lo;
            F3_SH:   strb = 4'b0011 << addr_lo;
            F3_SW:   strb = 4'b1111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Data is replicated across all lanes so the strobes alone select the
    // bytes that land in memory.
    function automatic logic [31:0] store_data(input logic [2:0] funct3,
                                               input logic [31:0] rs2);
        logic [31:0] data;
        case (funct3)
            F3_SB:   data = {4{rs2[7:0]}};
            F3_SH:   data = {2{rs2[15:0]}};
            default: data = rs2;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align -- combinational extraction of load data from a 32-bit bus word.
//
// Ports:
//   rdata     in  32  raw word returned by the data memory
//   funct3    in  3   load funct3 (size / signedness)
//   addr_lo   in  2   byte offset of the access within the word
//   read_data out 32  selected lane, sign-extended for byte/halfword loads
//   wb_mask   out 32  write-back mask (narrows LBU/LHU to zero-extension)
// -----------------------------------------------------------------------------
module load_align
    import common::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] read_data,
    output logic [31:0] wb_mask
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = lane[addr_lo];
    // Halfword alignment is guaranteed upstream, so only addr_lo[1] matters.
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wb_mask = load_wb_mask(funct3);
        case (funct3)
            F3_LB, F3_LBU: read_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH, F3_LHU: read_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:         read_data = rdata;
            default:       read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- pipeline memory stage: issues one load/store at a time on a
// req/gnt/rvalid data bus and hands a registered result to write-back.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid / in_ready             upstream handshake (ready only in IDLE)
//   field, alu_result, rs2_data,
//   pc_in                           instruction, address/result, store data, PC
//   dmem_req, dmem_we, dmem_addr,
//   dmem_wdata, dmem_wstrb          bus request side
//   dmem_gnt, dmem_rvalid,
//   dmem_rdata                      bus grant / response side
//   out_valid / out_ready           downstream handshake (valid in DONE)
//   field_out, alu_result_out,
//   pc_out, read_data, wb_mask      registered results
//   misalign, bus_err               exception flags, meaningful with out_valid
// -----------------------------------------------------------------------------
module mem_access
    import common::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  instr_field  field,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc_in,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,

    output logic        out_valid,
    input  logic        out_ready,
    output instr_field  field_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] pc_out,
    output logic [31:0] read_data,
    output logic [31:0] wb_mask,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t  state_reg, state_next;

    instr_field  field_reg;
    logic [31:0] alu_result_reg;
    logic [31:0] pc_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        we_reg;
    logic        is_load_reg;
    logic [31:0] read_data_reg;
    logic [31:0] wb_mask_reg;
    logic        misalign_reg;
    logic        bus_err_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic        in_is_load;
    logic        in_is_store;
    logic        in_is_mem;
    logic        in_misalign;

    logic        accept;
    logic        capture;
    logic        timeout;
    logic        timeout_hit;

    logic [31:0] align_read_data;
    logic [31:0] align_wb_mask;

    // ---------------------------------------------------------------- decode
    assign in_is_load  = (field.opcode == OPCODE_LOAD);
    assign in_is_store = (field.opcode == OPCODE_STORE);
    assign in_is_mem   = in_is_load | in_is_store;
    assign in_misalign = is_misaligned(field.funct3, alu_result[1:0]);

    // Fires on the last of TIMEOUT_CYCLES cycles spent in REQ/RESP.
    assign timeout_hit = (cnt_reg == CNT_LAST);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (in_is_mem && !in_misalign) ? REQ : DONE;
                end
            end
            REQ: begin
                // A response arriving with the grant completes immediately.
                if (dmem_gnt && dmem_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end else if (dmem_gnt) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    load_align u_load_align (
        .rdata     (dmem_rdata),
        .funct3    (field_reg.funct3),
        .addr_lo   (alu_result_reg[1:0]),
        .read_data (align_read_data),
        .wb_mask   (align_wb_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_reg      <= '0;
            alu_result_reg <= '0;
            pc_reg         <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            we_reg         <= 1'b0;
            is_load_reg    <= 1'b0;
            read_data_reg  <= '0;
            wb_mask_reg    <= '0;
            misalign_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
            cnt_reg        <= '0;
        end else if (accept) begin
            field_reg      <= field;
            alu_result_reg <= alu_result;
            pc_reg         <= pc_in;
            addr_reg       <= {alu_result[31:2], 2'b00};
            is_load_reg    <= in_is_load;
            we_reg         <= in_is_store;
            if (in_is_store) begin
                wdata_reg <= store_data(field.funct3, rs2_data);
                wstrb_reg <= store_strobe(field.funct3, alu_result[1:0]);
            end else begin
                wdata_reg <= '0;
                wstrb_reg <= '0;
            end
            read_data_reg  <= '0;
            wb_mask_reg    <= in_is_load ? load_wb_mask(field.funct3) : 32'hFFFF_FFFF;
            misalign_reg   <= in_is_mem & in_misalign;
            bus_err_reg    <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            if (state_reg == REQ || state_reg == RESP) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (capture && is_load_reg) begin
                read_data_reg <= align_read_data;
                wb_mask_reg   <= align_wb_mask;
            end
            if (timeout) begin
                bus_err_reg   <= 1'b1;
                read_data_reg <= '0;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign in_ready       = (state_reg == IDLE);
    assign dmem_req       = (state_reg == REQ);
    assign dmem_we        = (state_reg == REQ) & we_reg;
    assign dmem_addr      = addr_reg;
    assign dmem_wdata     = wdata_reg;
    assign dmem_wstrb     = wstrb_reg;

    assign out_valid      = (state_reg == DONE);
    assign field_out      = field_reg;
    assign alu_result_out = alu_result_reg;
    assign pc_out         = pc_reg;
    assign read_data      = read_data_reg;
    assign wb_mask        = wb_mask_reg;
    assign misalign       = misalign_reg;
    assign bus_err        = bus_err_reg;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access -- directed self-checking bench for mem_access.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access;
    import common::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    instr_field  field;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] pc_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_ready;
    instr_field  field_out;
    logic [31:0] alu_result_out;
    logic [31:0] pc_out;
    logic [31:0] read_data;
    logic [31:0] wb_mask;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT_CYCLES(256)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .field          (field),
        .alu_result     (alu_result),
        .rs2_data       (rs2_data),
        .pc_in          (pc_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .field_out      (field_out),
        .alu_result_out (alu_result_out),
        .pc_out         (pc_out),
        .read_data      (read_data),
        .wb_mask        (wb_mask),
        .misalign       (misalign),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_field(input logic [6:0] op, input logic [2:0] f3);
        return {7'b0, 5'd2, 5'd1, f3, 5'd7, op};
    endfunction

    // Presents one instruction for a single cycle; call from a falling edge in IDLE.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] pc);
        field      = mk_field(op, f3);
        alu_result = addr;
        rs2_data   = data;
        pc_in      = pc;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        $display("issue op=%b f3=%b addr=%h data=%h pc=%h", op, f3, addr, data, pc);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic held;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        field       = '0;
        alu_result  = '0;
        rs2_data    = '0;
        pc_in       = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        out_ready   = 1'b0;

        // ---------------------------------------------------- reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_dmem_req",  32'(dmem_req),   32'd0);
        check("rst_dmem_we",   32'(dmem_we),    32'd0);
        check("rst_wstrb",     32'(dmem_wstrb), 32'd0);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_misalign",  32'(misalign),   32'd0);
        check("rst_bus_err",   32'(bus_err),    32'd0);
        check("rst_read_data", read_data,       32'd0);
        check("rst_wb_mask",   wb_mask,         32'd0);
        check("rst_dmem_addr", dmem_addr,       32'd0);
        check("rst_pc_out",    pc_out,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ------------------------------- LB 0x1003, gnt+rvalid together
        issue(7'b0000011, 3'b000, 32'h0000_1003, 32'h0, 32'h0000_0100);
        check("lb_req",      32'(dmem_req), 32'd1);
        check("lb_we",       32'(dmem_we),  32'd0);
        check("lb_addr",     dmem_addr,     32'h0000_1000);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        check("lb_out_valid", 32'(out_valid), 32'd1);
        check("lb_read_data", read_data,      32'hFFFF_FF80);
        check("lb_wb_mask",   wb_mask,        32'hFFFF_FFFF);
        check("lb_misalign",  32'(misalign),  32'd0);
        check("lb_bus_err",   32'(bus_err),   32'd0);
        check("lb_pc_out",    pc_out,         32'h0000_0100);
        check("lb_field_out", field_out,      mk_field(7'b0000011, 3'b000));
        release_result();
        check("lb_back_idle", 32'(in_ready), 32'd1);

        // ------------------------------------------------ SH 0x2002
        issue(7'b0100011, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0000_0104);
        check("sh_req",   32'(dmem_req), 32'd1);
        check("sh_we",    32'(dmem_we),  32'd1);
        check("sh_addr",  dmem_addr,     32'h0000_2000);
        check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
        check("sh_wdata", dmem_wdata,    32'hABCD_ABCD);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("sh_resp_req",   32'(dmem_req),  32'd0);
        check("sh_resp_valid", 32'(out_valid), 32'd0);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("sh_out_valid", 32'(out_valid), 32'd1);
        check("sh_read_data", read_data,      32'd0);
        check("sh_misalign",  32'(misalign),  32'd0);
        release_result();

        // ----------------------------------------- SB 0x2001 strobes
        issue(7'b0100011, 3'b000, 32'h0000_2001, 32'h0000_005A, 32'h0000_0108);
        check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
        check("sb_wdata", dmem_wdata,      32'h5A5A_5A5A);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        release_result();

        // ------------------------------------------- LW 0x3001 misaligned
        issue(7'b0000011, 3'b010, 32'h0000_3001, 32'h0, 32'h0000_010C);
        check("lw_mis_req",      32'(dmem_req),  32'd0);
        check("lw_mis_valid",    32'(out_valid), 32'd1);
        check("lw_mis_misalign", 32'(misalign),  32'd1);
        check("lw_mis_bus_err",  32'(bus_err),   32'd0);
        release_result();

        // --------------------- non-memory op, no acceptance while in DONE
        issue(7'b0110011, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0000_0110);
        check("alu_valid",    32'(out_valid), 32'd1);
        check("alu_result",   alu_result_out, 32'hDEAD_BEEF);
        check("alu_wb_mask",  wb_mask,        32'hFFFF_FFFF);
        check("alu_misalign", 32'(misalign),  32'd0);
        check("alu_req",      32'(dmem_req),  32'd0);
        pc_in = 32'h0000_0114; in_valid = 1'b1; out_ready = 1'b1;
        check("done_not_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check("done_to_idle",  32'(in_ready),  32'd1);
        check("done_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("next_accepted", pc_out, 32'h0000_0114);
        release_result();

        // ----------------------- LHU 0x4000, gnt after 3 cycles, rvalid +2
        issue(7'b0000011, 3'b101, 32'h0000_4000, 32'h0, 32'h0000_0118);
        for (int i = 0; i < 4; i++) begin
            check("lhu_req_held", 32'(dmem_req), 32'd1);
            if (i == 3) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        check("lhu_resp_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("lhu_resp_wait", 32'(out_valid), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        check("lhu_valid",     32'(out_valid), 32'd1);
        check("lhu_read_data", read_data,      32'hFFFF_F00D);
        check("lhu_wb_mask",   wb_mask,        32'h0000_FFFF);
        release_result();

        // ------------------------------------- LW with no grant: timeout
        issue(7'b0000011, 3'b010, 32'h0000_5000, 32'h0, 32'h0000_011C);
        n = 0;
        while (dmem_req && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", 32'(n),         32'd256);
        check("to_valid",      32'(out_valid), 32'd1);
        check("to_bus_err",    32'(bus_err),   32'd1);
        check("to_misalign",   32'(misalign),  32'd0);
        check("to_read_data",  read_data,      32'd0);
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && bus_err === 1'b1 && pc_out === 32'h0000_011C))
                held = 1'b0;
        end
        check("to_outputs_held", 32'(held), 32'd1);
        release_result();
        check("to_back_idle", 32'(in_ready), 32'd1);

        // ---------------------- reset mid-RESP, late rvalid in IDLE ignored
        issue(7'b0000011, 3'b010, 32'h0000_6000, 32'h0, 32'h0000_0120);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rr_in_resp", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rr_async_idle", 32'(in_ready), 32'd1);
        check("rr_pc_cleared", pc_out,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rr_late_rvalid_valid", 32'(out_valid), 32'd0);
        check("rr_late_rvalid_idle",  32'(in_ready),  32'd1);
        check("rr_late_rvalid_data",  read_data,      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum cycles spent in REQ or RESP before a bus error is raised.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 in_valid  in  1  upstream (execute) presents an instruction.
REQ-005 in_ready  out  1  block accepts an instruction; high only in IDLE.
REQ-006 field  in  common::instr_field  decoded instruction; opcode and funct3 used, rest passed through.
REQ-007 alu_result  in  32  effective address for load/store, result otherwise.
REQ-008 rs2_data  in  32  store data.
REQ-009 pc_in  in  32  instruction PC, passed through.
REQ-010 dmem_req / dmem_we  out  1 / 1  bus request / write enable.
REQ-011 dmem_addr  out  32  word-aligned address (alu_result with bits [1:0] cleared).
REQ-012 dmem_wdata / dmem_wstrb  out  32 / 4  lane-shifted store data / byte strobes.
REQ-013 dmem_gnt / dmem_rvalid / dmem_rdata  in  1 / 1 / 32  grant, response valid, read data.
REQ-014 out_valid  in-flight result valid to write-back; out_ready  in  1  write-back consumes it.
REQ-015 field_out, alu_result_out, pc_out, read_data (32), wb_mask (32)  out  registered results.
REQ-016 misalign / bus_err  out  1  exception flags, qualified by out_valid.

Function
REQ-017 FSM states IDLE, REQ, RESP, DONE.
REQ-018 IDLE and in_valid: capture all inputs; opcode 0000011 or 0100011 and aligned -> REQ; otherwise -> DONE.
REQ-019 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; misaligned -> DONE with misalign=1, no bus request.
REQ-020 REQ: dmem_req=1, address/data/strobes stable until dmem_gnt; gnt -> RESP (store and load alike).
REQ-021 RESP: wait for dmem_rvalid; on rvalid capture dmem_rdata (loads) -> DONE.
REQ-022 dmem_gnt and dmem_rvalid in the same REQ cycle: go directly to DONE with data captured.
REQ-023 DONE: out_valid=1, outputs held stable; out_ready -> IDLE. No new acceptance in the same cycle.
REQ-024 Load extraction: byte lane = addr[1:0] (SB/LB) or addr[1] (halfword); LB/LH sign-extend to 32 bits, LW unchanged.
REQ-025 wb_mask: LB/LH/LW 0xFFFFFFFF, LBU 0x000000FF, LHU 0x0000FFFF; non-load 0xFFFFFFFF.
REQ-026 Store strobes: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; wdata replicated (byte x4, half x2).
REQ-027 Cycle counter cleared on entering REQ, increments in REQ/RESP; reaching TIMEOUT_CYCLES -> DONE with bus_err=1, read_data=0.
REQ-028 Minimum latency: non-memory 1 cycle to out_valid; load/store with gnt and rvalid both in the next cycle, 2 cycles.
REQ-029 misalign and bus_err never both set; both 0 for normal completion.

Reset
REQ-030 rst_n low: state IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, out_valid=0, misalign=0, bus_err=0, counter=0.
REQ-031 read_data, wb_mask, dmem_addr, dmem_wdata, pass-through registers reset to 0.
REQ-032 Reset mid-transaction abandons it immediately; late dmem_rvalid in IDLE is ignored.

Structure
REQ-033 mem_state_t enum, load/store funct3 constants and opcode constants 0000011/0100011 live in package common.
REQ-034 One sub-module load_align (combinational: rdata, funct3, addr[1:0] -> read_data, wb_mask); FSM stays in mem_access.

Verification
REQ-035 LB at 0x1003, rdata 0x80FF_0000 -> read_data 0xFFFFFF80, wb_mask 0xFFFFFFFF.
REQ-036 SH at 0x2002, rs2 0x1234ABCD -> dmem_addr 0x2000, wstrb 1100, wdata 0xABCDABCD.
REQ-037 LW at 0x3001 -> no dmem_req, out_valid next cycle, misalign=1.
REQ-038 LHU at 0x4000 with gnt withheld 3 cycles, rvalid 2 cycles later, rdata 0x0000_F00D -> read_data 0xFFFFF00D, wb_mask 0x0000FFFF, dmem_req held 4 cycles.
REQ-039 Load with no gnt for TIMEOUT_CYCLES -> bus_err=1, read_data 0; out_ready low 5 cycles -> outputs held; rst_n pulsed in RESP -> IDLE, in_ready=1.
